// File: rtl/mem_arb_pkg.sv
// Shared constants, id-width helper and tag type for the memory port arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int req_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]               valid_i,
    input  logic                             en_i,
    input  logic [req_id_w(NUM_REQ)-1:0]     ptr_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [req_id_w(NUM_REQ)-1:0]     id_o
);

    localparam int IDW = req_id_w(NUM_REQ);

    logic           found;
    int             scanIdx;
    logic [IDW-1:0] scanBits;

    always_comb begin
        grant_o  = '0;
        id_o     = '0;
        found    = 1'b0;
        scanIdx  = 0;
        scanBits = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx  = (int'(ptr_i) + k) % NUM_REQ;
            scanBits = IDW'(scanIdx);
            if (!found && valid_i[scanBits]) begin
                found = 1'b1;
                id_o  = scanBits;
            end
        end
        if (found && en_i) begin
            grant_o[id_o] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port, with a fixed-latency read tag pipe.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int BANKING_FACTOR = 1,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     arb_en,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0]                       req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]         req_addr,
    input  logic [NUM_REQ*BANKING_FACTOR*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [NUM_REQ-1:0]                       resp_valid,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0]     resp_data,
    output logic [ADDRESS_WIDTH-1:0]                 mem_req_addr,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0]     mem_req_data,
    output logic                                     mem_read_en,
    output logic                                     mem_write_en,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0]     mem_resp_data,
`ifdef ARB_PERF_CNT_EN
    input  logic                                     perf_clr,
    output logic [NUM_REQ*16-1:0]                    perf_grant_cnt,
    output logic [NUM_REQ*16-1:0]                    perf_stall_cnt,
`endif
    output logic                                     busy
);

    localparam int BW  = BANKING_FACTOR * DATA_WIDTH;
    localparam int IDW = req_id_w(NUM_REQ);

    logic [IDW-1:0]           rrPtr_q, rrPtr_d;
    logic [IDW-1:0]           grantId;
    logic                     handshake;
    logic [ADDRESS_WIDTH-1:0] addrArr [NUM_REQ];
    logic [BW-1:0]            dataArr [NUM_REQ];

    logic [ADDRESS_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [BW-1:0]            memData_q, memData_d;
    logic                     memRd_q, memRd_d;
    logic                     memWr_q, memWr_d;
    logic [2:0]               issueId_q, issueId_d;

    tag_t                     tagPipe_q [MEM_LATENCY];
    tag_t                     tagIn;
    tag_t                     tail;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid_i (req_valid),
        .en_i    (arb_en),
        .ptr_i   (rrPtr_q),
        .grant_o (req_ready),
        .id_o    (grantId)
    );

    // The arbiter only raises a ready bit for a valid requester, so any ready is a handshake.
    assign handshake = |req_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addrArr[i] = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            dataArr[i] = req_wdata[i*BW +: BW];
        end
    end

    always_comb begin
        rrPtr_d   = rrPtr_q;
        memAddr_d = '0;
        memData_d = '0;
        memRd_d   = 1'b0;
        memWr_d   = 1'b0;
        issueId_d = '0;
        if (handshake) begin
            rrPtr_d   = (grantId == IDW'(NUM_REQ-1)) ? '0 : grantId + IDW'(1);
            memAddr_d = addrArr[grantId];
            memData_d = dataArr[grantId];
            memRd_d   = !req_write[grantId];
            memWr_d   = req_write[grantId];
            issueId_d = 3'(grantId);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q   <= '0;
            memAddr_q <= '0;
            memData_q <= '0;
            memRd_q   <= 1'b0;
            memWr_q   <= 1'b0;
            issueId_q <= '0;
        end else begin
            rrPtr_q   <= rrPtr_d;
            memAddr_q <= memAddr_d;
            memData_q <= memData_d;
            memRd_q   <= memRd_d;
            memWr_q   <= memWr_d;
            issueId_q <= issueId_d;
        end
    end

    assign mem_req_addr = memAddr_q;
    assign mem_req_data = memData_q;
    assign mem_read_en  = memRd_q;
    assign mem_write_en = memWr_q;

    // The pipe starts one edge after the strobe, so its tail lines up with the memory data.
    always_comb begin
        tagIn       = '0;
        tagIn.valid = memRd_q;
        tagIn.id    = issueId_q;
        tail        = tagPipe_q[MEM_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_LATENCY; k++) tagPipe_q[k] <= '0;
        end else begin
            tagPipe_q[0] <= tagIn;
            for (int k = 1; k < MEM_LATENCY; k++) tagPipe_q[k] <= tagPipe_q[k-1];
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        busy       = memRd_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tail.valid && (tail.id == 3'(i));
        end
        if (tail.valid) resp_data = mem_resp_data;
        for (int k = 0; k < MEM_LATENCY; k++) busy = busy | tagPipe_q[k].valid;
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] grantCnt_q [NUM_REQ];
    logic [15:0] stallCnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grantCnt_q[i] <= '0;
                stallCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grantCnt_q[i] != 16'hFFFF)
                    grantCnt_q[i] <= grantCnt_q[i] + 16'd1;
                if (req_valid[i] && !req_ready[i] && stallCnt_q[i] != 16'hFFFF)
                    stallCnt_q[i] <= stallCnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        perf_stall_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[i*16 +: 16] = grantCnt_q[i];
            perf_stall_cnt[i*16 +: 16] = stallCnt_q[i];
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified-buffer memory port between NUM_REQ requesters: systolic wrapper, host loader, vector unit.
- Round-robin grants, at most one memory transaction per cycle.
- Tracks in-flight reads through a fixed-latency tag pipe and returns each read response only to the requester that issued it.
- Sits between requester masters and the banked memory.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDRESS_WIDTH, 13, memory word address width.
- DATA_WIDTH, 32, element width.
- BANKING_FACTOR, 1, elements per memory beat; beat width BW = BANKING_FACTOR*DATA_WIDTH.
- MEM_LATENCY, 3, cycles from mem_read_en to valid mem_resp_data (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arb_en  in  1  grants allowed when high
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  flattened addresses, requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*BW  flattened write data
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready
- resp_valid  out  NUM_REQ  one-hot read-response valid
- resp_data  out  BW  read data, broadcast to all requesters
- mem_req_addr  out  ADDRESS_WIDTH  registered address
- mem_req_data  out  BW  registered write data
- mem_read_en  out  1  registered read strobe
- mem_write_en  out  1  registered write strobe
- mem_resp_data  in  BW  memory read data
- busy  out  1  high while any read is in flight

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - On rst: rr_ptr=0, tag pipe cleared, mem_* outputs=0, busy=0, resp_valid=0.
- Arbitration (combinational):
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner]=1 only if arb_en=1; all other ready bits 0.
  - req_ready may depend on req_valid.
  - Requesters hold valid, write, addr and wdata stable until handshake.
- Pointer update: on a handshake by requester g, rr_ptr <= (g+1) mod NUM_REQ at the clock edge. No handshake leaves rr_ptr unchanged.
- Issue:
  - Handshake in cycle T gives, at T+1: mem_req_addr, mem_req_data and exactly one of mem_read_en or mem_write_en = 1.
  - With no handshake, the strobes are 0 and addr/data are 0.
- Tag pipe:
  - MEM_LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads {mem_read_en, id of the cycle-T grant}, aligned with the T+1 strobe.
  - Writes insert valid=0.
- Response:
  - When the tail tag is valid (cycle T+1+MEM_LATENCY): resp_valid[id]=1 and resp_data=mem_resp_data, combinational from the tail.
  - Otherwise resp_data=0.
  - Read latency from handshake to response is MEM_LATENCY+1 cycles.
  - Throughput is one transaction per cycle; back-to-back reads from different requesters return in issue order.
- busy = OR of all tag valids and mem_read_en.
- Boundaries:
  - arb_en low: no new grants. In-flight reads still complete and respond. Pointer frozen.
  - No requesters valid: pipe drains, idle.
  - Single requester valid continuously: granted every cycle.
  - Read and write to the same address in consecutive grants: issue order preserved. Memory handles the hazard; no forwarding.
  - rst mid-transaction: in-flight responses are dropped and never delivered.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds input perf_clr.
  - Adds outputs perf_grant_cnt (NUM_REQ*16) and perf_stall_cnt (NUM_REQ*16).
  - grant_cnt[i] counts handshakes of requester i.
  - stall_cnt[i] counts cycles with req_valid[i]&!req_ready[i].
  - Counters saturate at 16'hFFFF. They clear on rst or perf_clr; perf_clr wins over a simultaneous increment.
- When undefined: none of these ports or counters exist, and arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - MAX_REQ=8 constant.
  - function req_id_w(n) = $clog2(n) with a minimum of 1.
  - typedef tag_t {logic valid; logic [2:0] id}.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs valid, en, ptr; outputs one-hot grant and encoded id. Purely combinational.
- The top level owns rr_ptr, issue registers, the tag pipe and the counters.

Test Plan:
- Reset, then req0 reads 0x010 (mem returns 0xDEADBEEF) -> mem_read_en at T+1 with addr 0x010; resp_valid=3'b001, resp_data=0xDEADBEEF at T+4 (MEM_LATENCY=3).
- All three requesters read continuously from rr_ptr=0 -> grant sequence 0,1,2,0,1,2; responses return in the same order, one per cycle, no gaps.
- req1 writes 0x0AB to 0x020 while req2 reads 0x021 -> req1 granted first (write strobe, data 0x0AB); req2 granted next cycle; only resp_valid[2] pulses.
- arb_en=0 for 5 cycles with two reads in flight -> both responses delivered; req_ready stays 0; busy falls after the last response.
- rst asserted one cycle after a read handshake -> mem_read_en=0 and no resp_valid pulse within the next 6 cycles; rr_ptr=0 (req0 wins next contest).
- ARB_PERF_CNT_EN defined, req0 and req1 valid for 10 cycles -> perf_grant_cnt 5/5, perf_stall_cnt 5/5; perf_clr zeroes both.
